scan_chain_ctrl: RTL and testbench
==================================

Name: scan_chain_ctrl

Overview:
- Sequences a serial scan chain built from async-reset D flip-flops (mux-D scan style) for power and pattern characterisation runs.
- On each start it performs three phases:
  - shift-in: serially loads a parallel stimulus pattern into the chain;
  - capture: asserts capture enable for a programmable number of cycles;
  - shift-out: serially unloads the chain into a parallel response register.
- Sits between the test sequencer (start/done handshake) and the flop chain (scan_en, scan_si, scan_so, cap_en).

Parameters:
- CHAIN_LEN, 16: number of flops in the chain. Legal range 2..64.
- CNT_W, 7: phase counter width. Must satisfy 2^CNT_W > max(CHAIN_LEN, CAP_CYCLES).
- CAP_CYCLES, 1: number of cycles cap_en is held high in CAPTURE. Legal range 1..15.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- RSTB  input  1  asynchronous, active-low reset.
- start  input  1  begin one shift-in/capture/shift-out sequence; sampled only in IDLE.
- abort  input  1  synchronous abort; returns to IDLE with no done.
- pattern  input  CHAIN_LEN  stimulus word; latched on the accepted start.
- scan_so  input  1  serial output of the last chain flop.
- scan_en  output  1  chain shift enable.
- scan_si  output  1  serial data into the first chain flop.
- cap_en  output  1  functional capture enable.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when response is valid.
- response  output  CHAIN_LEN  unloaded chain contents; holds until the next done.

Behaviour:
- Reset (RSTB=0, asynchronous, takes effect immediately):
  - State = IDLE.
  - Counter = 0, shift register = 0, response = 0.
  - scan_en, scan_si, cap_en, busy, done all = 0.
  - Deassertion of RSTB is synchronous to CLK. The first start is sampled on the first posedge after release.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- States: IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, DONE.
- IDLE:
  - If start=1 and abort=0: sreg <= pattern, cnt <= 0, go to SHIFT_IN.
  - Otherwise remain in IDLE. abort in IDLE has no effect.
- SHIFT_IN (CHAIN_LEN cycles):
  - scan_en=1, scan_si=sreg[0]; each cycle sreg shifts right by 1 with 0 entering at the MSB.
  - When cnt=CHAIN_LEN-1: cnt <= 0, go to CAPTURE.
  - Result: pattern[0] ends in the far (scan_so) flop and pattern[CHAIN_LEN-1] in the first flop.
- CAPTURE (CAP_CYCLES cycles):
  - scan_en=0, cap_en=1, scan_si=0.
  - When cnt=CAP_CYCLES-1: cnt <= 0, go to SHIFT_OUT.
- SHIFT_OUT (CHAIN_LEN cycles):
  - scan_en=1, scan_si=0.
  - Each cycle: response_shadow <= {scan_so, response_shadow[CHAIN_LEN-1:1]}.
  - After CHAIN_LEN cycles, response_shadow[i] = the bit that was held in the flop loaded from pattern[i].
  - When cnt=CHAIN_LEN-1: go to DONE.
- DONE (1 cycle):
  - response <= response_shadow, done=1, scan_en=0, cap_en=0.
  - Next state is IDLE; busy drops in the same cycle done drops.
- Timing: with start accepted at edge 0, scan_en is high for edges 1..CHAIN_LEN, cap_en for the following CAP_CYCLES cycles, then shift-out. done is high for exactly one cycle, 2*CHAIN_LEN+CAP_CYCLES+1 cycles after the start edge.
- start while busy: ignored, not queued.
- start held high continuously: a new sequence is accepted on the first IDLE cycle after DONE, i.e. back-to-back with a 1-cycle IDLE gap.
- abort=1 in any non-IDLE state:
  - Next state IDLE; scan_en, cap_en and scan_si = 0 next cycle.
  - No done pulse; response keeps its previous value.
  - abort and start together in IDLE: stay in IDLE.
- Async reset mid-sequence: all state and outputs clear immediately; the chain contents are undefined to the controller.
- Counter arithmetic: unsigned and compare-terminated; the counter never wraps.

Test Plan:
1. Loopback, CHAIN_LEN=16, CAP_CYCLES=1.
   - Bench chain is 16 async-reset flops; capture loads each flop with ~Q.
   - pattern=16'hA5C3 with a start pulse -> response=16'h5A3C.
   - done pulse exactly 34 cycles after the start edge; scan_en high for 16 cycles, low for 1, high for 16.
2. Back-to-back: start held high with patterns 16'hFFFF then 16'h0001 -> responses 16'h0000 then 16'hFFFE; one IDLE cycle between done and the next scan_en.
3. CAP_CYCLES=3 with the capture model toggling each cycle, pattern 16'h00F0 -> response 16'hFF0F (odd toggles); cap_en high for exactly 3 cycles.
4. abort asserted on the 5th SHIFT_OUT cycle -> next cycle IDLE, busy=0, scan_en=0, no done; response retains the prior value 16'h5A3C.
5. RSTB pulled low mid-CAPTURE -> cap_en, busy, response=0 immediately without a clock edge; after release, a new start with 16'h1234 -> response 16'hEDCB.
6. start pulsed during SHIFT_IN -> ignored; exactly one done per accepted start.

Source files
------------

// File: rtl/scan_chain_ctrl.sv
// Scan chain sequencer: shift-in a stimulus pattern, pulse capture, shift-out
// the response. Every output is a flop; nothing combinational reaches a port.
module scan_chain_ctrl #(
   parameter int CHAIN_LEN  = 16,
   parameter int CNT_W      = 7,
   parameter int CAP_CYCLES = 1
) (
   input  logic                 CLK,
   input  logic                 RSTB,
   input  logic                 start,
   input  logic                 abort,
   input  logic [CHAIN_LEN-1:0] pattern,
   input  logic                 scan_so,
   output logic                 scan_en,
   output logic                 scan_si,
   output logic                 cap_en,
   output logic                 busy,
   output logic                 done,
   output logic [CHAIN_LEN-1:0] response
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SHIFT_IN,
      S_CAPTURE,
      S_SHIFT_OUT,
      S_DONE
   } state_t;

   localparam logic [CNT_W-1:0] LP_LEN_LAST = CNT_W'(CHAIN_LEN - 1);
   localparam logic [CNT_W-1:0] LP_CAP_LAST = CNT_W'(CAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] LP_ONE      = CNT_W'(1);

   state_t               r_state;
   logic [CNT_W-1:0]     r_cnt;
   logic [CHAIN_LEN-1:0] r_sreg;
   logic [CHAIN_LEN-1:0] r_shadow;
   logic [CHAIN_LEN-1:0] r_response;
   logic                 r_scan_en;
   logic                 r_scan_si;
   logic                 r_cap_en;
   logic                 r_busy;
   logic                 r_done;

   logic [CHAIN_LEN-1:0] w_pat_shr;
   logic [CHAIN_LEN-1:0] w_sreg_shr;
   logic [CHAIN_LEN-1:0] w_shadow_nxt;
   logic                 w_abort;

   // scan_si is registered, so bit 0 leaves with the accepting edge and
   // the shift register holds the remaining bits.
   assign w_pat_shr    = {1'b0, pattern[CHAIN_LEN-1:1]};
   assign w_sreg_shr   = {1'b0, r_sreg[CHAIN_LEN-1:1]};
   assign w_shadow_nxt = {scan_so, r_shadow[CHAIN_LEN-1:1]};
   assign w_abort      = abort && (r_state != S_IDLE);

   always_ff @(posedge CLK or negedge RSTB) begin
      if (!RSTB) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_sreg     <= '0;
         r_shadow   <= '0;
         r_response <= '0;
         r_scan_en  <= 1'b0;
         r_scan_si  <= 1'b0;
         r_cap_en   <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_abort) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_scan_en <= 1'b0;
            r_scan_si <= 1'b0;
            r_cap_en  <= 1'b0;
            r_busy    <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (start && !abort) begin
                     r_sreg    <= w_pat_shr;
                     r_scan_si <= pattern[0];
                     r_cnt     <= '0;
                     r_scan_en <= 1'b1;
                     r_busy    <= 1'b1;
                     r_state   <= S_SHIFT_IN;
                  end
               end
               S_SHIFT_IN: begin
                  if (r_cnt == LP_LEN_LAST) begin
                     r_cnt     <= '0;
                     r_scan_en <= 1'b0;
                     r_scan_si <= 1'b0;
                     r_cap_en  <= 1'b1;
                     r_state   <= S_CAPTURE;
                  end else begin
                     r_cnt     <= r_cnt + LP_ONE;
                     r_scan_si <= r_sreg[0];
                     r_sreg    <= w_sreg_shr;
                  end
               end
               S_CAPTURE: begin
                  if (r_cnt == LP_CAP_LAST) begin
                     r_cnt     <= '0;
                     r_cap_en  <= 1'b0;
                     r_scan_en <= 1'b1;
                     r_state   <= S_SHIFT_OUT;
                  end else begin
                     r_cnt <= r_cnt + LP_ONE;
                  end
               end
               S_SHIFT_OUT: begin
                  r_shadow <= w_shadow_nxt;
                  if (r_cnt == LP_LEN_LAST) begin
                     r_cnt      <= '0;
                     r_scan_en  <= 1'b0;
                     r_response <= w_shadow_nxt;
                     r_done     <= 1'b1;
                     r_state    <= S_DONE;
                  end else begin
                     r_cnt <= r_cnt + LP_ONE;
                  end
               end
               S_DONE: begin
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
               default: begin
                  r_state <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign scan_en  = r_scan_en;
   assign scan_si  = r_scan_si;
   assign cap_en   = r_cap_en;
   assign busy     = r_busy;
   assign done     = r_done;
   assign response = r_response;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl: two controllers (1 and 3 capture cycles) each
// driving a 16-flop chain model whose capture inverts every flop.
module tb_scan_chain_ctrl;

   logic        CLK;
   logic        RSTB;

   logic        start, abort, scan_so, scan_en, scan_si, cap_en, busy, done;
   logic [15:0] pattern, response;
   logic        start2, abort2, scan_so2, scan_en2, scan_si2, cap_en2;
   logic        busy2, done2;
   logic [15:0] pattern2, response2;

   logic [15:0] chain1, chain2;

   int n_checks;
   int n_fail;

   scan_chain_ctrl #(.CHAIN_LEN(16), .CNT_W(7), .CAP_CYCLES(1)) u_dut1 (
      .CLK(CLK), .RSTB(RSTB), .start(start), .abort(abort),
      .pattern(pattern), .scan_so(scan_so), .scan_en(scan_en),
      .scan_si(scan_si), .cap_en(cap_en), .busy(busy), .done(done),
      .response(response)
   );

   scan_chain_ctrl #(.CHAIN_LEN(16), .CNT_W(7), .CAP_CYCLES(3)) u_dut2 (
      .CLK(CLK), .RSTB(RSTB), .start(start2), .abort(abort2),
      .pattern(pattern2), .scan_so(scan_so2), .scan_en(scan_en2),
      .scan_si(scan_si2), .cap_en(cap_en2), .busy(busy2), .done(done2),
      .response(response2)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // chain[0] is the flop fed by scan_si, chain[15] drives scan_so
   always @(posedge CLK or negedge RSTB) begin
      if (!RSTB) chain1 <= '0;
      else if (scan_en) chain1 <= {chain1[14:0], scan_si};
      else if (cap_en) chain1 <= ~chain1;
   end
   always @(posedge CLK or negedge RSTB) begin
      if (!RSTB) chain2 <= '0;
      else if (scan_en2) chain2 <= {chain2[14:0], scan_si2};
      else if (cap_en2) chain2 <= ~chain2;
   end
   assign scan_so  = chain1[15];
   assign scan_so2 = chain2[15];

   task automatic test_reset();
      RSTB = 1'b0;
      start = 0; abort = 0; pattern = '0;
      start2 = 0; abort2 = 0; pattern2 = '0;
      #12;
      n_checks++;
      if ({scan_en, scan_si, cap_en, busy, done} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_ctl: got %b expected 00000",
                  {scan_en, scan_si, cap_en, busy, done});
      end
      n_checks++;
      if (response !== 16'h0000 || response2 !== 16'h0000) begin
         n_fail++;
         $display("FAIL reset_resp: got %h/%h expected 0000",
                  response, response2);
      end
      @(negedge CLK);
      RSTB = 1'b1;
   endtask

   task automatic test_loopback();
      int sen, sen_first, cap, cap_first, dfirst, dcnt;
      logic en17;
      logic [15:0] resp;
      sen = 0; sen_first = 0; cap = 0; cap_first = 0;
      dfirst = 0; dcnt = 0; en17 = 1'b1; resp = '0;
      @(negedge CLK);
      pattern = 16'hA5C3; start = 1'b1;
      @(posedge CLK);
      #1 start = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge CLK);
         if (scan_en) begin
            sen++;
            if (sen_first == 0) sen_first = i;
         end
         if (cap_en) begin
            cap++;
            if (cap_first == 0) cap_first = i;
         end
         if (done) begin
            dcnt++;
            if (dfirst == 0) begin
               dfirst = i;
               resp = response;
            end
         end
         if (i == 17) en17 = scan_en;
      end
      n_checks++;
      if (resp !== 16'h5A3C) begin
         n_fail++;
         $display("FAIL loop_resp: got %h expected 5a3c", resp);
      end
      n_checks++;
      if (dfirst !== 34 || dcnt !== 1) begin
         n_fail++;
         $display("FAIL loop_done: at %0d count %0d expected 34/1",
                  dfirst, dcnt);
      end
      n_checks++;
      if (sen !== 32 || sen_first !== 1 || en17 !== 1'b0) begin
         n_fail++;
         $display("FAIL loop_scan_en: cnt %0d first %0d mid %b exp 32/1/0",
                  sen, sen_first, en17);
      end
      n_checks++;
      if (cap !== 1 || cap_first !== 17) begin
         n_fail++;
         $display("FAIL loop_cap: cnt %0d first %0d expected 1/17",
                  cap, cap_first);
      end
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL loop_idle: busy %b expected 0", busy);
      end
   endtask

   task automatic test_abort();
      int dcnt;
      dcnt = 0;
      @(negedge CLK);
      pattern = 16'h0F0F; start = 1'b1;
      @(posedge CLK);
      #1 start = 1'b0;
      for (int i = 1; i <= 21; i++) @(negedge CLK);
      abort = 1'b1;
      @(posedge CLK);
      #1 abort = 1'b0;
      n_checks++;
      if ({busy, scan_en, cap_en, scan_si, done} !== 5'b0) begin
         n_fail++;
         $display("FAIL abort_idle: got %b expected 00000",
                  {busy, scan_en, cap_en, scan_si, done});
      end
      for (int i = 0; i < 40; i++) begin
         @(negedge CLK);
         if (done) dcnt++;
      end
      n_checks++;
      if (dcnt !== 0) begin
         n_fail++;
         $display("FAIL abort_done: got %0d pulses expected 0", dcnt);
      end
      n_checks++;
      if (response !== 16'h5A3C) begin
         n_fail++;
         $display("FAIL abort_resp: got %h expected 5a3c", response);
      end
   endtask

   task automatic test_back_to_back();
      int d1, d2, dcnt;
      logic [15:0] r1, r2;
      logic busy35, en35, en36;
      d1 = 0; d2 = 0; dcnt = 0; r1 = 'x; r2 = 'x;
      busy35 = 1'b1; en35 = 1'b1; en36 = 1'b0;
      @(negedge CLK);
      pattern = 16'hFFFF; start = 1'b1;
      @(posedge CLK);
      #1 pattern = 16'h0001;
      for (int i = 1; i <= 75; i++) begin
         @(negedge CLK);
         if (done) begin
            dcnt++;
            if (d1 == 0) begin
               d1 = i; r1 = response;
            end else if (d2 == 0) begin
               d2 = i; r2 = response;
            end
         end
         if (i == 35) begin
            busy35 = busy; en35 = scan_en;
         end
         if (i == 36) begin
            en36 = scan_en;
            start = 1'b0;
         end
      end
      n_checks++;
      if (r1 !== 16'h0000 || d1 !== 34) begin
         n_fail++;
         $display("FAIL b2b_first: resp %h at %0d expected 0000 at 34",
                  r1, d1);
      end
      n_checks++;
      if (r2 !== 16'hFFFE || d2 !== 69 || dcnt !== 2) begin
         n_fail++;
         $display("FAIL b2b_second: resp %h at %0d n %0d exp fffe/69/2",
                  r2, d2, dcnt);
      end
      n_checks++;
      if (busy35 !== 1'b0 || en35 !== 1'b0 || en36 !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_gap: busy %b en %b next_en %b expected 0 0 1",
                  busy35, en35, en36);
      end
   endtask

   task automatic test_cap3();
      int cap, cap_first, dfirst, sen;
      logic [15:0] resp;
      cap = 0; cap_first = 0; dfirst = 0; sen = 0; resp = '0;
      @(negedge CLK);
      pattern2 = 16'h00F0; start2 = 1'b1;
      @(posedge CLK);
      #1 start2 = 1'b0;
      for (int i = 1; i <= 45; i++) begin
         @(negedge CLK);
         if (scan_en2) sen++;
         if (cap_en2) begin
            cap++;
            if (cap_first == 0) cap_first = i;
         end
         if (done2 && dfirst == 0) begin
            dfirst = i; resp = response2;
         end
      end
      n_checks++;
      if (resp !== 16'hFF0F) begin
         n_fail++;
         $display("FAIL cap3_resp: got %h expected ff0f", resp);
      end
      n_checks++;
      if (cap !== 3 || cap_first !== 17 || sen !== 32) begin
         n_fail++;
         $display("FAIL cap3_cap: cnt %0d first %0d en %0d exp 3/17/32",
                  cap, cap_first, sen);
      end
      n_checks++;
      if (dfirst !== 36) begin
         n_fail++;
         $display("FAIL cap3_done: at %0d expected 36", dfirst);
      end
   endtask

   task automatic test_reset_mid();
      int dfirst;
      logic cap17;
      logic [15:0] resp;
      dfirst = 0; resp = '0; cap17 = 1'b0;
      @(negedge CLK);
      pattern = 16'hBEEF; start = 1'b1;
      @(posedge CLK);
      #1 start = 1'b0;
      for (int i = 1; i <= 17; i++) begin
         @(negedge CLK);
         if (i == 17) cap17 = cap_en;
      end
      n_checks++;
      if (cap17 !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_mid_cap: cap_en %b expected 1", cap17);
      end
      RSTB = 1'b0;
      #1;
      n_checks++;
      if ({cap_en, busy, scan_en, done} !== 4'b0 || response !== 16'h0) begin
         n_fail++;
         $display("FAIL rst_mid_clear: ctl %b resp %h expected 0000/0000",
                  {cap_en, busy, scan_en, done}, response);
      end
      #2 RSTB = 1'b1;
      @(negedge CLK);
      pattern = 16'h1234; start = 1'b1;
      @(posedge CLK);
      #1 start = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge CLK);
         if (done && dfirst == 0) begin
            dfirst = i; resp = response;
         end
      end
      n_checks++;
      if (resp !== 16'hEDCB || dfirst !== 34) begin
         n_fail++;
         $display("FAIL rst_mid_rerun: resp %h at %0d expected edcb at 34",
                  resp, dfirst);
      end
   endtask

   task automatic test_start_ignored();
      int dcnt, dfirst;
      logic [15:0] resp;
      dcnt = 0; dfirst = 0; resp = '0;
      @(negedge CLK);
      pattern = 16'h3C3C; start = 1'b1;
      @(posedge CLK);
      #1 start = 1'b0;
      for (int i = 1; i <= 80; i++) begin
         @(negedge CLK);
         if (done) begin
            dcnt++;
            if (dfirst == 0) begin
               dfirst = i; resp = response;
            end
         end
         if (i == 5) begin
            start = 1'b1; pattern = 16'hFFFF;
         end
         if (i == 6) start = 1'b0;
      end
      n_checks++;
      if (dcnt !== 1 || dfirst !== 34) begin
         n_fail++;
         $display("FAIL ignore_done: count %0d first %0d expected 1/34",
                  dcnt, dfirst);
      end
      n_checks++;
      if (resp !== 16'hC3C3) begin
         n_fail++;
         $display("FAIL ignore_resp: got %h expected c3c3", resp);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_loopback();
      test_abort();
      test_back_to_back();
      test_cap3();
      test_reset_mid();
      test_start_ignored();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
